// File: rtl/imm_ext_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_ext_pipe
// Brief    : Pipelined immediate extender for the decode stage. Builds the
//            sign/zero-extended immediate from instr[31:7] and flags illegal
//            type codes and shift amounts. Results go through a valid/ready
//            output register backed by a one-entry skid register, so the
//            upstream ready is a plain register output. A saturating counter
//            tracks how many illegal beats were accepted.
// Revision : 1.0 - initial release
// ============================================================================
module imm_ext_pipe #(
  parameter int IMM_WIDTH = 25,
  parameter int OUT_WIDTH = 32,
  parameter int TAG_WIDTH = 32,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_flush,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [2:0]           i_imm_type,
  input  logic [IMM_WIDTH-1:0] i_imm,
  input  logic [TAG_WIDTH-1:0] i_tag,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [OUT_WIDTH-1:0] o_imm_ext,
  output logic [TAG_WIDTH-1:0] o_tag,
  output logic                 o_illegal,
  output logic [CNT_WIDTH-1:0] o_illegal_cnt
);

  // Immediate type codes
  localparam logic [2:0] C_TYPE_I     = 3'b000;
  localparam logic [2:0] C_TYPE_S     = 3'b001;
  localparam logic [2:0] C_TYPE_B     = 3'b010;
  localparam logic [2:0] C_TYPE_J     = 3'b011;
  localparam logic [2:0] C_TYPE_U     = 3'b100;
  localparam logic [2:0] C_TYPE_CSR   = 3'b101;
  localparam logic [2:0] C_TYPE_SHAMT = 3'b110;

  // On RV32 a shift amount of 32 or more is not encodable
  localparam logic C_RV32 = (OUT_WIDTH == 32);

  // i_imm[24] is instr[31], the architectural sign bit for every signed type
  logic                 w_sign;
  logic [OUT_WIDTH-1:0] w_u_imm;
  logic [OUT_WIDTH-1:0] w_ext;
  logic                 w_illegal;
  logic                 w_accept;
  logic                 w_consume;

  assign w_sign = i_imm[24];

  // U-type already fills 32 bits; only a wider datapath needs extension bits
  generate
    if (OUT_WIDTH > 32) begin : g_u_wide
      assign w_u_imm = {{(OUT_WIDTH-32){w_sign}}, i_imm[24:5], 12'b0};
    end else begin : g_u_narrow
      assign w_u_imm = {i_imm[24:5], 12'b0};
    end
  endgenerate

  // Combinational extension of the offered beat; illegal beats carry zero data
  always_comb begin
    w_ext     = '0;
    w_illegal = 1'b0;
    case (i_imm_type)
      C_TYPE_I:   w_ext = {{(OUT_WIDTH-12){w_sign}}, i_imm[24:13]};
      C_TYPE_S:   w_ext = {{(OUT_WIDTH-12){w_sign}}, i_imm[24:18], i_imm[4:0]};
      C_TYPE_B:   w_ext = {{(OUT_WIDTH-12){w_sign}}, i_imm[0], i_imm[23:18],
                           i_imm[4:1], 1'b0};
      C_TYPE_J:   w_ext = {{(OUT_WIDTH-20){w_sign}}, i_imm[12:5], i_imm[13],
                           i_imm[23:14], 1'b0};
      C_TYPE_U:   w_ext = w_u_imm;
      C_TYPE_CSR: w_ext = {{(OUT_WIDTH-5){1'b0}}, i_imm[12:8]};
      C_TYPE_SHAMT: begin
        if (C_RV32 && i_imm[18]) begin
          w_illegal = 1'b1;
        end else begin
          w_ext = {{(OUT_WIDTH-6){1'b0}}, i_imm[18:13]};
        end
      end
      default:    w_illegal = 1'b1;
    endcase
  end

  // Output register, skid register, registered ready and illegal counter
  logic                 out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0] out_imm_q,   out_imm_d;
  logic [TAG_WIDTH-1:0] out_tag_q,   out_tag_d;
  logic                 out_ill_q,   out_ill_d;
  logic                 skid_valid_q, skid_valid_d;
  logic [OUT_WIDTH-1:0] skid_imm_q,   skid_imm_d;
  logic [TAG_WIDTH-1:0] skid_tag_q,   skid_tag_d;
  logic                 skid_ill_q,   skid_ill_d;
  logic                 ready_q,      ready_d;
  logic [CNT_WIDTH-1:0] cnt_q,        cnt_d;

  // Ready is the registered "skid empty" flag, so there is no path from i_ready
  assign w_accept  = i_valid & ready_q;
  assign w_consume = out_valid_q & i_ready;

  // Next-state: flush beats accept/drain; otherwise refill OUT first, SKID second
  always_comb begin
    out_valid_d  = out_valid_q;
    out_imm_d    = out_imm_q;
    out_tag_d    = out_tag_q;
    out_ill_d    = out_ill_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_tag_d   = skid_tag_q;
    skid_ill_d   = skid_ill_q;
    cnt_d        = cnt_q;

    if (i_flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (!out_valid_q || w_consume) begin
        if (skid_valid_q) begin
          // Drain: ready was low this cycle, so no new beat can collide
          out_valid_d  = 1'b1;
          out_imm_d    = skid_imm_q;
          out_tag_d    = skid_tag_q;
          out_ill_d    = skid_ill_q;
          skid_valid_d = 1'b0;
        end else if (w_accept) begin
          out_valid_d = 1'b1;
          out_imm_d   = w_ext;
          out_tag_d   = i_tag;
          out_ill_d   = w_illegal;
        end else begin
          out_valid_d = 1'b0;
        end
      end else if (w_accept) begin
        // OUT is stalled, park the new beat in SKID
        skid_valid_d = 1'b1;
        skid_imm_d   = w_ext;
        skid_tag_d   = i_tag;
        skid_ill_d   = w_illegal;
      end

      if (w_accept && w_illegal && (cnt_q != {CNT_WIDTH{1'b1}})) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    ready_d = ~skid_valid_d;
  end

  // State registers with synchronous reset; reset takes priority over flush
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_tag_q    <= '0;
      out_ill_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_tag_q   <= '0;
      skid_ill_q   <= 1'b0;
      ready_q      <= 1'b1;
      cnt_q        <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_imm_q    <= out_imm_d;
      out_tag_q    <= out_tag_d;
      out_ill_q    <= out_ill_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_tag_q   <= skid_tag_d;
      skid_ill_q   <= skid_ill_d;
      ready_q      <= ready_d;
      cnt_q        <= cnt_d;
    end
  end

  assign o_ready       = ready_q;
  assign o_valid       = out_valid_q;
  assign o_imm_ext     = out_imm_q;
  assign o_tag         = out_tag_q;
  assign o_illegal     = out_ill_q;
  assign o_illegal_cnt = cnt_q;

endmodule
`default_nettype wire

// File: doc/imm_ext_pipe.md
# imm_ext_pipe

Pipelined, parametrised immediate extender for the decode stage. Takes the 25-bit instruction field `instr[31:7]` plus an immediate-type code and returns a sign- or zero-extended immediate of width `OUT_WIDTH` (RV32 or RV64). It adds a shift-amount type, illegal-type/illegal-shamt detection, a tag passthrough, and a saturating illegal-event counter. It sits between the instruction register and the execute operand muxes, behind a valid/ready handshake with a 2-entry output/skid buffer, so back-pressure never loses a beat.

## Interface
- `IMM_WIDTH`, 25: input field width; `i_imm[k]` = `instr[k+7]`. Fixed at 25.
- `OUT_WIDTH`, 32: extended width; legal values are 32 and 64.
- `TAG_WIDTH`, 32: width of the sideband tag (PC or instruction ID) carried alongside the immediate.
- `CNT_WIDTH`, 8: width of the illegal-event counter.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `i_flush` in 1: drops all buffered beats.
- `i_valid` in 1: input beat valid.
- `o_ready` out 1: block can accept a beat.
- `i_imm_type` in 3: type code.
- `i_imm` in 25: `instr[31:7]`.
- `i_tag` in TAG_WIDTH: sideband tag, passed through unchanged.
- `o_valid` out 1: output beat valid.
- `i_ready` in 1: downstream accepts the output beat.
- `o_imm_ext` out OUT_WIDTH: extended immediate.
- `o_tag` out TAG_WIDTH: tag of the output beat.
- `o_illegal` out 1: output beat had an illegal type or illegal shamt.
- `o_illegal_cnt` out CNT_WIDTH: saturating count of accepted illegal beats.

## Operation
**Type codes.** `s` = `i_imm[24]` replicated to fill `OUT_WIDTH`.
- 000 I: `{s, i_imm[24:13]}`.
- 001 S: `{s, i_imm[24:18], i_imm[4:0]}`.
- 010 B: `{s, i_imm[0], i_imm[23:18], i_imm[4:1], 0}`.
- 011 J: `{s, i_imm[12:5], i_imm[13], i_imm[23:14], 0}`.
- 100 U: `{s, i_imm[24:5], 12'b0}`. At 32 bits no extension bits remain; at 64 bits bits 63:32 = `i_imm[24]`.
- 101 CSR uimm: zero-extend `i_imm[12:8]`.
- 110 SHAMT: zero-extend `i_imm[18:13]` (6 bits). When `OUT_WIDTH`=32 and `i_imm[18]`=1 the beat is illegal.
- 111: reserved, always illegal.

**Illegal beats.** Data is forced to 0 and `o_illegal`=1. Still transferred normally.

**Extension timing.** Extension is combinational on the input side; the result is registered on accept.

**Buffering.** Output register (OUT) plus one skid register (SKID). `o_ready` = !SKID.valid, driven from a register with no combinational path from `i_ready`.

**Accept rule.** A beat is accepted when `i_valid & o_ready`.
- If !OUT.valid, or OUT is being consumed (`i_ready`) → load OUT.
- Otherwise → load SKID.

**Drain rule.** When OUT is consumed and SKID.valid → OUT ← SKID, SKID cleared. A new accept in the same cycle is impossible because `o_ready` is low.

**Ordering.** Strict FIFO; no beat is dropped except by flush or reset.

**Flush.** `i_flush`=1 clears OUT.valid and SKID.valid on the next edge. An input accepted in the same cycle is discarded and not counted. Flush has priority over accept and drain.

**Counter.** `o_illegal_cnt` increments on each accepted illegal beat unless flush is asserted that cycle. It saturates at all-ones and is cleared only by `rst`.

**Reset.** `rst` has priority over `i_flush`.

## Timing
- Latency: accepted at edge N, `o_valid`=1 from cycle N+1.
- Throughput: 1 beat per cycle while `i_ready`=1.
- Reset values: `o_valid`=0, `o_ready`=1, `o_imm_ext`=0, `o_tag`=0, `o_illegal`=0, `o_illegal_cnt`=0.
- Reset asserted mid-stream: both registers are emptied at the next edge. `o_ready` reads 1 in the cycle after reset.
- Stable output: while `o_valid`=1 and `i_ready`=0, `o_imm_ext`, `o_tag` and `o_illegal` hold stable.
- Full condition: with SKID occupied, `o_ready`=0 from the cycle after the SKID load until the cycle after drain.
- Simultaneous drain of OUT and a fresh accept with SKID empty: the new beat goes to OUT, SKID stays empty.

## Test plan
- **B-type.** `OUT_WIDTH`=32, type 010, `i_imm`=0x1FC001D (beq -4) → `o_imm_ext`=0xFFFFFFFC one cycle later, `o_illegal`=0.
- **I-type and U-type widths.**
  - Type 000, `i_imm[24:13]`=0xFFF → 0xFFFFFFFF.
  - Type 100, `i_imm[24:5]`=0x80000, `OUT_WIDTH`=64 → 0xFFFFFFFF80000000.
  - Same U-type beat with `OUT_WIDTH`=32 → 0x80000000.
- **Illegal handling.**
  - `OUT_WIDTH`=32, type 110, `i_imm[18:13]`=0x21 → `o_imm_ext`=0, `o_illegal`=1, `o_illegal_cnt` 0→1.
  - `OUT_WIDTH`=64 → 0x21, legal.
  - Type 111 → illegal.
  - 300 illegal beats → count holds at 255.
- **Back-pressure.** `i_ready`=0, offer tags A, B, C back to back:
  - A is held on the output, B is in SKID, `o_ready`=0, C is held at the input.
  - Raise `i_ready` → A, B, C appear on consecutive cycles with matching tags.
  - No gaps; `o_ready` returns to 1 one cycle after B moves to OUT.
- **Flush.** OUT and SKID full, assert `i_flush` with `i_valid`=1 and an illegal beat offered → next cycle `o_valid`=0, `o_ready`=1, counter unchanged.
- **Reset mid-stream.** Assert `rst` during a stream with both registers full → all outputs reach their reset values after one edge. The first beat after release emerges with 1-cycle latency.
